// File: rtl/fir_sym_serial_mac.sv
// Purpose : symmetric (linear-phase) FIR, folded delay line, one shared MAC per clock.
// Latency : out_valid pulses in the cycle after edge E0+H+1 (12 edges for NTAPS=22).
// Backpressure: in_ready is high only in IDLE; one accepted sample per H+2 cycles at most.
// Ports:
//   CLK_Filter, rst_n (sync, active-low)     clock and reset
//   in_valid/in_ready/in_data                 sample handshake (unsigned DATA_W)
//   flush                                     clear history and abort the current sample
//   coef_we/coef_addr/coef_wdata              coefficient load, honoured only in IDLE
//   out_valid/out_data/out_sat                one-cycle result pulse, data/sat held between pulses
module fir_sym_serial_mac #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int NTAPS     = 22,
  parameter int OUT_W     = 20,
  parameter int OUT_SHIFT = 0,
  localparam int H        = NTAPS / 2,
  localparam int ADDR_W   = (H > 1) ? $clog2(H) : 1
) (
  input  logic              CLK_Filter,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat
);

  // idx must be able to hold H after the last MAC edge, even when H is a power of two.
  localparam int IDX_W  = $clog2(H + 1);
  localparam int TAP_W  = $clog2(NTAPS);
  localparam int PROD_W = DATA_W + 1 + COEF_W;
  localparam int ACC_W  = DATA_W + 1 + COEF_W + $clog2(H);
  localparam int SAT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [SAT_W-1:0] SAT_MAX = SAT_W'((64'd1 << OUT_W) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  x_q [NTAPS];
  logic [DATA_W-1:0]  x_d [NTAPS];
  logic [COEF_W-1:0]  c_q [H];
  logic [COEF_W-1:0]  c_d [H];
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_sat_q, out_sat_d;

  logic [TAP_W-1:0]   tap_lo;
  logic [TAP_W-1:0]   tap_hi;
  logic [COEF_W-1:0]  coef_sel;
  logic [DATA_W:0]    pair_sum;
  logic [PROD_W-1:0]  prod;
  logic [SAT_W-1:0]   shifted;
  logic               clip;
  logic               coef_addr_ok;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Folded tap pair: x[idx] and its mirror x[N-1-idx] share coefficient c[idx].
  always_comb begin
    tap_lo   = TAP_W'(idx_q);
    tap_hi   = TAP_W'(NTAPS - 1) - tap_lo;
    // idx reaches H once the last MAC is done; keep the coefficient read in range.
    coef_sel = (idx_q < IDX_W'(H)) ? c_q[idx_q[ADDR_W-1:0]] : '0;
    pair_sum = {1'b0, x_q[tap_lo]} + {1'b0, x_q[tap_hi]};
    prod     = PROD_W'(coef_sel) * PROD_W'(pair_sum);
    shifted  = SAT_W'(acc_q) >> OUT_SHIFT;
    clip     = (shifted > SAT_MAX);
    coef_addr_ok = ({1'b0, coef_addr} < (ADDR_W + 1)'(H));
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    x_d         = x_q;
    c_d         = c_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (flush) begin
      // Abort: history and accumulator cleared, coefficients kept, no sample taken.
      for (int i = 0; i < NTAPS; i++) begin
        x_d[i] = '0;
      end
      acc_d   = '0;
      idx_d   = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A write coincident with an accepted sample is visible to that sample's MACs.
          if (coef_we && coef_addr_ok) begin
            c_d[coef_addr] = coef_wdata;
          end
          if (in_valid) begin
            x_d[0] = in_data;
            for (int i = 1; i < NTAPS; i++) begin
              x_d[i] = x_q[i-1];
            end
            idx_d   = '0;
            acc_d   = '0;
            state_d = S_MAC;
          end
        end
        S_MAC: begin
          acc_d = acc_q + ACC_W'(prod);
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(H - 1)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          out_valid_d = 1'b1;
          out_data_d  = clip ? OUT_W'(SAT_MAX) : OUT_W'(shifted);
          out_sat_d   = clip;
          state_d     = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_Filter) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
      end
      for (int i = 0; i < H; i++) begin
        c_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      x_q         <= x_d;
      c_q         <= c_d;
    end
  end

endmodule

// File: tb/tb_fir_sym_serial_mac.sv
// Bench for fir_sym_serial_mac: two instances (OUT_SHIFT 0 and 1) share all inputs.
// A sum-of-products reference with a busy countdown predicts every output cycle;
// directed tests pin that reference with hand-computed literals.
module tb_fir_sym_serial_mac;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        flush;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [7:0]  coef_wdata;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [19:0] out_data0, out_data1;
  logic        out_sat0, out_sat1;

  fir_sym_serial_mac #(.OUT_SHIFT(0)) dut (
    .CLK_Filter(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .out_valid(out_valid0), .out_data(out_data0), .out_sat(out_sat0)
  );

  fir_sym_serial_mac #(.OUT_SHIFT(1)) dut_s1 (
    .CLK_Filter(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .out_valid(out_valid1), .out_data(out_data1), .out_sat(out_sat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int      mh [22];
  int      mc [11];
  int      busy;
  int      pending;
  int      cyc = 0;
  bit      model_live = 0;
  bit      exp_valid, exp_ready, exp_s0, exp_s1;
  int      exp_d0, exp_d1;
  int      m_res [$];
  int      acc_t [$];

  task automatic sat_out(input int raw, input int sh, output int d, output bit s);
    int v;
    v = raw >>> sh;
    if (v > 1048575) begin d = 1048575; s = 1; end
    else begin d = v; s = 0; end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 22; i++) mh[i] = 0;
      for (int i = 0; i < 11; i++) mc[i] = 0;
      busy = 0; exp_valid = 0;
      exp_d0 = 0; exp_s0 = 0; exp_d1 = 0; exp_s1 = 0;
      model_live = 1;
    end else begin
      exp_valid = 0;
      if (flush) begin
        for (int i = 0; i < 22; i++) mh[i] = 0;
        busy = 0;
      end else if (busy == 0) begin
        if (coef_we && coef_addr < 11) mc[coef_addr] = coef_wdata;
        if (in_valid) begin
          for (int i = 21; i > 0; i--) mh[i] = mh[i-1];
          mh[0] = in_data;
          pending = 0;
          for (int k = 0; k < 22; k++) pending += mc[(k < 11) ? k : 21 - k] * mh[k];
          busy = 12;
          acc_t.push_back(cyc);
        end
      end else begin
        busy--;
        if (busy == 0) begin
          exp_valid = 1;
          m_res.push_back(pending);
          sat_out(pending, 0, exp_d0, exp_s0);
          sat_out(pending, 1, exp_d1, exp_s1);
        end
      end
    end
    exp_ready = (busy == 0);
    cyc++;
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (model_live) begin
      check("in_ready",    32'(in_ready0),  32'(exp_ready));
      check("in_ready_s1", 32'(in_ready1),  32'(exp_ready));
      check("out_valid",   32'(out_valid0), 32'(exp_valid));
      check("out_valid_s1",32'(out_valid1), 32'(exp_valid));
      check("out_data",    32'(out_data0),  exp_d0);
      check("out_sat",     32'(out_sat0),   32'(exp_s0));
      check("out_data_s1", 32'(out_data1),  exp_d1);
      check("out_sat_s1",  32'(out_sat1),   32'(exp_s1));
    end
  end

  int          n_pulse = 0;
  logic [19:0] last_d0, last_d1;
  logic        last_s0, last_s1;
  always @(negedge clk) begin
    if (out_valid0) begin
      n_pulse++;
      last_d0 = out_data0; last_s0 = out_sat0;
      last_d1 = out_data1; last_s1 = out_sat1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; step(); step(); rst_n = 1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready0 && n < 50) begin step(); n++; end
    check("idle_wait", 32'(n < 50), 32'd1);
    step();
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [7:0] v);
    coef_addr = a; coef_wdata = v; coef_we = 1;
    step();
    coef_we = 0;
  endtask

  task automatic send(input logic [7:0] v, input bit hold);
    int n = 0;
    in_data = v; in_valid = 1;
    while (!in_ready0 && n < 50) begin step(); n++; end
    check("send_wait", 32'(n < 50), 32'd1);
    step();
    if (!hold) in_valid = 0;
  endtask

  int imp_exp [23] = '{100, 200, 300, 400, 500, 600, 700, 800, 900, 1000, 1100,
                       1100, 1000, 900, 800, 700, 600, 500, 400, 300, 200, 100, 0};
  int t4_exp [5] = '{7, 3, 100, 50, 20};
  int t3_exp [4] = '{10, 40, 70, 100};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst_n = 0; in_valid = 0; in_data = 0; flush = 0;
    coef_we = 0; coef_addr = 0; coef_wdata = 0;
    step(); step();
    check("rst_out_data", 32'(out_data0), 32'd0);
    check("rst_ready",    32'(in_ready0), 32'd1);
    rst_n = 1;

    // 1: impulse response
    m_res.delete();
    for (int k = 0; k < 11; k++) wr_coef(4'(k), 8'(k + 1));
    send(8'd100, 0);
    for (int i = 0; i < 22; i++) send(8'd0, 0);
    wait_idle();
    check("imp_count", 32'(m_res.size()), 32'd23);
    for (int i = 0; i < 23 && i < m_res.size(); i++) check("imp_val", m_res[i], imp_exp[i]);
    check("imp_last_dut", 32'(last_d0), 32'd0);

    // 2: saturation
    do_reset();
    m_res.delete();
    for (int k = 0; k < 11; k++) wr_coef(4'(k), 8'd255);
    for (int i = 0; i < 22; i++) send(8'd255, 0);
    wait_idle();
    check("sat_raw",    m_res[$], 32'd1430550);
    check("sat_data",   32'(last_d0), 32'hFFFFF);
    check("sat_flag",   32'(last_s0), 32'd1);
    check("shift_data", 32'(last_d1), 32'd715275);
    check("shift_flag", 32'(last_s1), 32'd0);

    // 3: in_valid held high
    do_reset();
    m_res.delete(); acc_t.delete();
    wr_coef(4'd0, 8'd1); wr_coef(4'd1, 8'd2);
    p0 = n_pulse;
    send(8'd10, 1); send(8'd20, 1); send(8'd30, 1); send(8'd40, 1);
    in_valid = 0;
    wait_idle();
    check("hs_accepts", 32'(acc_t.size()), 32'd4);
    for (int i = 1; i < acc_t.size(); i++) check("hs_spacing", 32'(acc_t[i] - acc_t[i-1]), 32'd13);
    check("hs_pulses", 32'(n_pulse - p0), 32'd4);
    for (int i = 0; i < 4 && i < m_res.size(); i++) check("hs_val", m_res[i], t3_exp[i]);

    // 4: coefficient write rules
    do_reset();
    m_res.delete();
    wr_coef(4'd0, 8'd1);
    send(8'd7, 0); wait_idle();
    send(8'd3, 0); wr_coef(4'd0, 8'd50); wait_idle();
    wr_coef(4'd0, 8'd50);
    send(8'd2, 0); wait_idle();
    wr_coef(4'd11, 8'd99);
    send(8'd1, 0); wait_idle();
    coef_addr = 4'd0; coef_wdata = 8'd5; coef_we = 1; in_data = 8'd4; in_valid = 1;
    step();
    coef_we = 0; in_valid = 0;
    wait_idle();
    check("coef_count", 32'(m_res.size()), 32'd5);
    for (int i = 0; i < 5 && i < m_res.size(); i++) check("coef_val", m_res[i], t4_exp[i]);
    check("coef_last_dut", 32'(last_d0), 32'd20);

    // 5: flush mid-MAC
    do_reset();
    m_res.delete();
    wr_coef(4'd0, 8'd1); wr_coef(4'd1, 8'd1);
    send(8'd9, 0); wait_idle();
    p0 = n_pulse;
    send(8'd8, 0);
    repeat (4) step();
    flush = 1; step(); flush = 0;
    check("flush_ready", 32'(in_ready0), 32'd1);
    flush = 1; in_valid = 1; in_data = 8'd55; step();
    flush = 0; in_valid = 0;
    repeat (14) step();
    check("flush_no_out", 32'(n_pulse - p0), 32'd0);
    send(8'd100, 0); wait_idle();
    check("flush_after", 32'(last_d0), 32'd100);
    check("flush_model", m_res[$], 32'd100);

    // 6: reset mid-MAC (no reset before: out_data still holds 100)
    wr_coef(4'd0, 8'd3);
    send(8'd10, 0);
    repeat (3) step();
    rst_n = 0; step();
    check("mid_rst_data",  32'(out_data0), 32'd0);
    check("mid_rst_sat",   32'(out_sat0),  32'd0);
    check("mid_rst_ready", 32'(in_ready0), 32'd1);
    rst_n = 1;
    send(8'd77, 0); wait_idle();
    check("post_rst_data", 32'(last_d0), 32'd0);
    check("post_rst_model", m_res[$], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
